game_sound: RTL and testbench
=============================

Name: game_sound

Overview:
- Audio back-end for the ball-and-paddle game.
- Consumes the controller's one-cycle `hit`, `wall` and `goal` event pulses and drives a 1-bit square-wave speaker output.
- Each event plays a fixed-pitch, fixed-duration tone. Events are arbitrated by priority, and a higher-priority event preempts a playing tone.
- Sits beside the video path, downstream of the game controller.

Parameters:
- TICK_CYCLES, 25000: clock cycles per duration tick (1 ms at 25 MHz).
- WALL_HALF, 55310: half-period in cycles of the wall tone (~226 Hz).
- HIT_HALF, 25510: half-period in cycles of the hit tone (~490 Hz).
- GOAL_HALF, 12755: half-period in cycles of the goal tone (~980 Hz).
- WALL_TICKS, 16: wall tone length in ticks.
- HIT_TICKS, 16: hit tone length in ticks.
- GOAL_TICKS, 250: goal tone length in ticks.
- JINGLE_TICKS, 150: length of each win-jingle note in ticks (used only with the macro).

Ports:
- clk, input, 1: system clock; the only clock.
- rst, input, 1: reset, synchronous, active-high.
- hit, input, 1: paddle-collision event.
- wall, input, 1: wall-collision event.
- goal, input, 1: goal-scored event.
- p1_win, input, 1: player 1 winner level.
- p2_win, input, 1: player 2 winner level.
- mute, input, 1: level; silences `speaker`.
- speaker, output, 1: square-wave audio.
- busy, output, 1: a tone or jingle is playing.
- sound_id, output, 3: 000 none, 001 wall, 010 hit, 011 goal, 100/101/110 jingle notes 1/2/3.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; `speaker`=0, `busy`=0, `sound_id`=000.
  - All counters and edge registers clear.
  - Reset asserted mid-tone takes effect at that edge; there is no residual toggle.
- Event detection:
  - Each of `hit`, `wall` and `goal` is rising-edge detected against its previous-cycle value.
  - An input held high counts as a single event.
- Priority: goal(3) > hit(2) > wall(1). Simultaneous events resolve to the highest.
- States are IDLE, TONE and, with the macro, JINGLE.
- IDLE:
  - On an event at edge E, go to TONE. `busy`=1 and `sound_id` is set from edge E.
  - At edge E: half-counter=0, tick prescaler=0, duration=0, `speaker`=0.
- TONE:
  - The half-counter increments every cycle. When it reaches HALF-1, `speaker` toggles and the counter returns to 0. The first rising edge of `speaker` is therefore HALF cycles after E.
  - The prescaler wraps at TICK_CYCLES-1, and duration increments on each wrap.
  - On the edge where prescaler=TICK_CYCLES-1 and duration=TICKS-1, go to IDLE with `speaker`=0, `busy`=0, `sound_id`=000.
  - `busy` is therefore high for exactly TICKS*TICK_CYCLES cycles.
- New event during TONE:
  - Strictly higher priority: restart fully as if from IDLE with the new sound.
  - Equal priority: restart the same sound.
  - Lower priority: ignore.
- Mute: `speaker` is forced to 0 while `mute`=1. The FSM, counters, `busy` and `sound_id` are unaffected.
- Width rules:
  - Counters are 17 bits for half-period, 15 bits for prescaler, 8 bits for duration.
  - Parameter values must fit these widths.
  - Comparisons are exact equality; no overflow wrap is possible within a legal configuration.

Optional Feature:
- Macro: GAME_SOUND_WIN_JINGLE_EN.
- Defined:
  - A rising edge of (p1_win | p2_win) enters JINGLE from any state.
  - JINGLE plays three notes back to back, each JINGLE_TICKS ticks long, with no gap:
    - note 1: WALL_HALF, `sound_id` 100;
    - note 2: HIT_HALF, `sound_id` 101;
    - note 3: GOAL_HALF, `sound_id` 110.
  - The half-counter and `speaker` reset to 0 at each note boundary.
  - `hit`, `wall` and `goal` are ignored during JINGLE.
  - After note 3 the block returns to IDLE.
- Undefined: `p1_win` and `p2_win` are ignored, the JINGLE state does not exist, and `sound_id[2]` is always 0.

Decomposition:
- Shared package `game_pkg` holds:
  - `sound_id` constants SND_NONE/WALL/HIT/GOAL/JNG1/JNG2/JNG3;
  - the state encoding IDLE/TONE/JINGLE;
  - the priority ranks.
- Sub-module `tone_divider` holds the half-period counter and `speaker` toggle.
  - Inputs: clk, rst, restart, half[16:0].
  - Output: wave.

Test Plan (params TICK_CYCLES=10, WALL_HALF=5, HIT_HALF=3, GOAL_HALF=2, WALL_TICKS=4, HIT_TICKS=4, GOAL_TICKS=8, JINGLE_TICKS=3):
- Single hit: `hit` pulse sampled at edge 0 → `busy`=1 and `sound_id`=010 for 40 cycles. `speaker` starts low, period 6, first high after 3 cycles, forced 0 at end.
- Preempt vs. ignore:
  - `wall` at 0, then `hit` at 10 → `sound_id` 010; `busy` stays high continuously until 40 cycles after edge 10.
  - `hit` at 0, then `wall` at 10 → ignored; `busy` ends after 40 cycles.
- Simultaneous: `goal` and `hit` in the same cycle → `sound_id` 011, `speaker` period 4, `busy` 80 cycles.
- Held input and mute:
  - `hit` held high for 50 cycles → one 40-cycle tone only.
  - `mute`=1 throughout → `speaker` constant 0, `busy` timing unchanged.
- Reset mid-tone: `rst` at cycle 20 of a goal tone → next edge `busy`=0, `sound_id`=000, `speaker`=0. A later `wall` plays normally.
- Jingle (macro defined):
  - `p1_win` rises → `sound_id` 100, 101, 110 for 30 cycles each, then IDLE.
  - `goal` during note 2 → ignored.
  - With the macro undefined, the same stimulus leaves the block in IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for the game audio back-end: sound ids, FSM encoding, priority ranks.
package game_pkg;

  localparam logic [2:0] SND_NONE = 3'b000;
  localparam logic [2:0] SND_WALL = 3'b001;
  localparam logic [2:0] SND_HIT  = 3'b010;
  localparam logic [2:0] SND_GOAL = 3'b011;
  localparam logic [2:0] SND_JNG1 = 3'b100;
  localparam logic [2:0] SND_JNG2 = 3'b101;
  localparam logic [2:0] SND_JNG3 = 3'b110;

  // Rank values deliberately equal the low bits of the matching sound id.
  localparam logic [1:0] RANK_NONE = 2'd0;
  localparam logic [1:0] RANK_WALL = 2'd1;
  localparam logic [1:0] RANK_HIT  = 2'd2;
  localparam logic [1:0] RANK_GOAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TONE   = 2'd1,
    JINGLE = 2'd2
  } state_t;

endpackage

// File: rtl/game_sound_if.sv
// Event inputs and audio outputs between the game controller and the sound block.
interface game_sound_if;
   logic       hit;
   logic       wall;
   logic       goal;
   logic       p1_win;
   logic       p2_win;
   logic       mute;
   logic       speaker;
   logic       busy;
   logic [2:0] sound_id;

   modport master (output hit, wall, goal, p1_win, p2_win, mute,
                   input  speaker, busy, sound_id);
   modport slave  (input  hit, wall, goal, p1_win, p2_win, mute,
                   output speaker, busy, sound_id);
endinterface

// File: rtl/tone_divider.sv
// Half-period counter producing a square wave; restart holds it at zero/low.
module tone_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        restart,
   input  logic [16:0] half,
   output logic        wave
);
   logic [16:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (cnt == half - 17'd1) begin
         cnt  <= '0;
         wave <= ~wave;
      end else begin
         cnt  <= cnt + 17'd1;
      end
   end
endmodule

// File: rtl/game_sound.sv
// Event-driven tone player with priority preemption.
// Define GAME_SOUND_WIN_JINGLE_EN to add the three-note win jingle.
module game_sound
   import game_pkg::*;
#(
   parameter int TICK_CYCLES  = 25000,
   parameter int WALL_HALF    = 55310,
   parameter int HIT_HALF     = 25510,
   parameter int GOAL_HALF    = 12755,
   parameter int WALL_TICKS   = 16,
   parameter int HIT_TICKS    = 16,
   parameter int GOAL_TICKS   = 250,
   parameter int JINGLE_TICKS = 150
) (
   input logic        clk,
   input logic        rst,
   game_sound_if.slave bus
);
   localparam logic [14:0] TICK_M1 = 15'(TICK_CYCLES - 1);

   state_t      state, state_n;
   logic [2:0]  sid, sid_n;
   logic [14:0] presc;
   logic [7:0]  dur;
   logic        hit_q, wall_q, goal_q;
   logic [1:0]  ev_rank;
   logic        load, restart, note_end, wave;
   logic [16:0] half;
   logic [7:0]  ticks_m1;

`ifdef GAME_SOUND_WIN_JINGLE_EN
   logic win_q, win_rise;
   assign win_rise = (bus.p1_win | bus.p2_win) & ~win_q;
`else
   logic unused_win;
   assign unused_win = bus.p1_win ^ bus.p2_win;
`endif

   always_comb begin
      ev_rank = RANK_NONE;
      if (bus.goal && !goal_q)      ev_rank = RANK_GOAL;
      else if (bus.hit && !hit_q)   ev_rank = RANK_HIT;
      else if (bus.wall && !wall_q) ev_rank = RANK_WALL;
   end

   // Jingle notes reuse the event pitches: note n plays rank n's half-period.
   always_comb begin
      half     = 17'(WALL_HALF);
      ticks_m1 = 8'(JINGLE_TICKS - 1);
      case (sid)
         SND_WALL: begin half = 17'(WALL_HALF); ticks_m1 = 8'(WALL_TICKS - 1); end
         SND_HIT:  begin half = 17'(HIT_HALF);  ticks_m1 = 8'(HIT_TICKS - 1);  end
         SND_GOAL: begin half = 17'(GOAL_HALF); ticks_m1 = 8'(GOAL_TICKS - 1); end
         SND_JNG2: half = 17'(HIT_HALF);
         SND_JNG3: half = 17'(GOAL_HALF);
         default:  half = 17'(WALL_HALF);
      endcase
   end

   assign note_end = (presc == TICK_M1) && (dur == ticks_m1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sid    <= SND_NONE;
         hit_q  <= 1'b0;
         wall_q <= 1'b0;
         goal_q <= 1'b0;
`ifdef GAME_SOUND_WIN_JINGLE_EN
         win_q  <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         sid    <= sid_n;
         hit_q  <= bus.hit;
         wall_q <= bus.wall;
         goal_q <= bus.goal;
`ifdef GAME_SOUND_WIN_JINGLE_EN
         win_q  <= bus.p1_win | bus.p2_win;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      sid_n   = sid;
      load    = 1'b0;
      case (state)
         IDLE: if (ev_rank != RANK_NONE) begin
            state_n = TONE;
            sid_n   = {1'b0, ev_rank};
            load    = 1'b1;
         end
         TONE: begin
            // Equal rank restarts the same sound; lower rank falls through.
            if (ev_rank >= sid[1:0]) begin
               sid_n = {1'b0, ev_rank};
               load  = 1'b1;
            end else if (note_end) begin
               state_n = IDLE;
               sid_n   = SND_NONE;
            end
         end
`ifdef GAME_SOUND_WIN_JINGLE_EN
         JINGLE: if (note_end) begin
            if (sid == SND_JNG3) begin
               state_n = IDLE;
               sid_n   = SND_NONE;
            end else begin
               sid_n = sid + 3'd1;
               load  = 1'b1;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            sid_n   = SND_NONE;
         end
      endcase
`ifdef GAME_SOUND_WIN_JINGLE_EN
      if (win_rise) begin
         state_n = JINGLE;
         sid_n   = SND_JNG1;
         load    = 1'b1;
      end
`endif
   end

   // Outputs
   always_comb begin
      restart      = load || (state_n == IDLE);
      bus.busy     = (state != IDLE);
      bus.sound_id = sid;
      bus.speaker  = wave & ~bus.mute;
   end

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         presc <= '0;
         dur   <= '0;
      end else if (presc == TICK_M1) begin
         presc <= '0;
         dur   <= dur + 8'd1;
      end else begin
         presc <= presc + 15'd1;
      end
   end

   tone_divider u_div (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .half    (half),
      .wave    (wave)
   );
endmodule

// File: tb/tb_game_sound.sv
// Directed bench for game_sound with small timing parameters.
module tb_game_sound;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_err = 0;
   int   n_chk = 0;

   game_sound_if bus ();

   game_sound #(
      .TICK_CYCLES(10), .WALL_HALF(5), .HIT_HALF(3), .GOAL_HALF(2),
      .WALL_TICKS(4), .HIT_TICKS(4), .GOAL_TICKS(8), .JINGLE_TICKS(3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one-cycle event; returns just after the sampling edge (k=0).
   task automatic fire(input bit h, input bit w, input bit g);
      bus.hit = h; bus.wall = w; bus.goal = g;
      @(negedge clk);
      bus.hit = 1'b0; bus.wall = 1'b0; bus.goal = 1'b0;
   endtask

   // Check cycles k0..k1-1 after the event edge of a tone of len cycles.
   task automatic watch(input string tag, input int sid, input int half,
                        input int len, input int k0, input int k1, input bit mt);
      int eb, es;
      for (int k = k0; k < k1; k++) begin
         eb = (k < len) ? 1 : 0;
         es = (eb == 1 && !mt) ? ((k / half) % 2) : 0;
         chk($sformatf("%s.busy@%0d", tag, k), int'(bus.busy), eb);
         chk($sformatf("%s.sid@%0d", tag, k), int'(bus.sound_id), eb == 1 ? sid : 0);
         chk($sformatf("%s.spk@%0d", tag, k), int'(bus.speaker), es);
         @(negedge clk);
      end
   endtask

   initial begin
      int exp_sid, exp_spk, kn, hv;
      bus.hit = 0; bus.wall = 0; bus.goal = 0;
      bus.p1_win = 0; bus.p2_win = 0; bus.mute = 0;
      repeat (3) @(negedge clk);
      chk("rst.busy", int'(bus.busy), 0);
      chk("rst.sid", int'(bus.sound_id), 0);
      chk("rst.spk", int'(bus.speaker), 0);
      rst = 1'b0;
      @(negedge clk);

      fire(1, 0, 0);
      watch("hit", 2, 3, 40, 0, 42, 0);

      fire(0, 1, 0);
      watch("pre_w", 1, 5, 40, 0, 9, 0);
      fire(1, 0, 0);
      watch("pre_h", 2, 3, 40, 0, 42, 0);

      fire(1, 0, 0);
      watch("ign", 2, 3, 40, 0, 9, 0);
      fire(0, 1, 0);
      watch("ign", 2, 3, 40, 10, 42, 0);

      fire(1, 0, 1);
      watch("sim", 3, 2, 80, 0, 82, 0);

      bus.hit = 1'b1;
      @(negedge clk);
      watch("held", 2, 3, 40, 0, 50, 0);
      bus.hit = 1'b0;
      watch("held", 2, 3, 40, 50, 53, 0);

      bus.mute = 1'b1;
      fire(1, 0, 0);
      watch("mute", 2, 3, 40, 0, 42, 1);
      bus.mute = 1'b0;

      fire(0, 0, 1);
      watch("rmid", 3, 2, 80, 0, 20, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rmid.busy", int'(bus.busy), 0);
      chk("rmid.sid", int'(bus.sound_id), 0);
      chk("rmid.spk", int'(bus.speaker), 0);
      @(negedge clk);
      fire(0, 1, 0);
      watch("rwall", 1, 5, 40, 0, 42, 0);

      bus.p1_win = 1'b1;
      @(negedge clk);
      for (int k = 0; k <= 92; k++) begin
`ifdef GAME_SOUND_WIN_JINGLE_EN
         kn = k % 30;
         hv = (k < 30) ? 5 : (k < 60) ? 3 : 2;
         exp_sid = (k < 90) ? 4 + k / 30 : 0;
         exp_spk = (k < 90) ? (kn / hv) % 2 : 0;
         chk($sformatf("jng.busy@%0d", k), int'(bus.busy), k < 90 ? 1 : 0);
         chk($sformatf("jng.sid@%0d", k), int'(bus.sound_id), exp_sid);
         chk($sformatf("jng.spk@%0d", k), int'(bus.speaker), exp_spk);
         bus.goal = (k == 39) ? 1'b1 : 1'b0;
`else
         kn = k; hv = 0; exp_sid = 0; exp_spk = 0;
         chk($sformatf("nojng.busy@%0d", k), int'(bus.busy), 0);
         chk($sformatf("nojng.sid@%0d", k), int'(bus.sound_id), exp_sid);
         chk($sformatf("nojng.spk@%0d", k), int'(bus.speaker), exp_spk);
`endif
         @(negedge clk);
      end
      bus.p1_win = 1'b0;
      bus.goal = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
